// File: rtl/ahb_slave_mem.sv
// AHB slave memory: word-organised array answering byte/halfword/word beats with programmable wait states.
// Latency: WAIT_STATES HREADY-low cycles per OKAY beat; error beats always take two cycles.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        I_SMEM_HCLK,
  input  logic        I_SMEM_HRESET_N,
  input  logic        I_SMEM_HSEL,
  input  logic [31:0] I_SMEM_HADDR,
  input  logic [1:0]  I_SMEM_HTRANS,
  input  logic        I_SMEM_HWRITE,
  input  logic [2:0]  I_SMEM_HSIZE,
  input  logic [2:0]  I_SMEM_HBURST,
  input  logic [31:0] I_SMEM_HWDATA,
  input  logic        I_SMEM_HREADY,
  output logic [31:0] O_SMEM_HRDATA,
  output logic        O_SMEM_HREADY,
  output logic [1:0]  O_SMEM_HRESP,
  output logic [15:0] O_SMEM_XFER_CNT
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  logic [31:0]           mem [2**ADDR_WIDTH];
  state_t                state, state_nxt;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] lat_waddr;
  logic [1:0]            lat_off;
  logic [2:0]            lat_size;
  logic                  lat_write;
  logic                  accept, beat_err, ready_int;
  logic [3:0]            lane_en;
  logic                  unused;

  // Every beat carries its own address, so burst type and the NSEQ/SEQ distinction carry no information here.
  assign unused = &{1'b0, I_SMEM_HBURST, I_SMEM_HTRANS[0]};

  assign accept   = ready_int & I_SMEM_HSEL & I_SMEM_HREADY & I_SMEM_HTRANS[1];
  assign beat_err = (I_SMEM_HSIZE > 3'b010) ||
                    (I_SMEM_HSIZE == 3'b001 && I_SMEM_HADDR[0]) ||
                    (I_SMEM_HSIZE == 3'b010 && I_SMEM_HADDR[1:0] != 2'b00) ||
                    ((I_SMEM_HADDR >> (ADDR_WIDTH + 2)) != 32'd0);

  always_ff @(posedge I_SMEM_HCLK or negedge I_SMEM_HRESET_N) begin
    if (!I_SMEM_HRESET_N) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!accept)       state_nxt = S_IDLE;
        else if (beat_err) state_nxt = S_ERR1;
        else               state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
      end
      S_WAIT:  if (wait_cnt <= 4'd1) state_nxt = S_DATA;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_int     = !(state == S_WAIT || state == S_ERR1);
    O_SMEM_HREADY = ready_int;
    O_SMEM_HRESP  = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
    O_SMEM_HRDATA = (state == S_DATA && !lat_write) ? mem[lat_waddr] : 32'd0;
  end

  always_ff @(posedge I_SMEM_HCLK or negedge I_SMEM_HRESET_N) begin
    if (!I_SMEM_HRESET_N) begin
      wait_cnt        <= 4'd0;
      lat_waddr       <= '0;
      lat_off         <= 2'b00;
      lat_size        <= 3'b000;
      lat_write       <= 1'b0;
      O_SMEM_XFER_CNT <= 16'd0;
    end else begin
      if (state_nxt == S_WAIT && state != S_WAIT) wait_cnt <= WS4;
      else if (state == S_WAIT)                   wait_cnt <= wait_cnt - 4'd1;
      if (accept) begin
        lat_waddr <= I_SMEM_HADDR[ADDR_WIDTH+1:2];
        lat_off   <= I_SMEM_HADDR[1:0];
        lat_size  <= I_SMEM_HSIZE;
        lat_write <= I_SMEM_HWRITE;
      end
      if (state == S_DATA) O_SMEM_XFER_CNT <= O_SMEM_XFER_CNT + 16'd1;
    end
  end

  always_comb begin
    case (lat_size)
      3'b000:  lane_en = 4'b0001 << lat_off;
      3'b001:  lane_en = lat_off[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Reset forces IDLE asynchronously, so a write caught mid data phase never reaches the array.
  always_ff @(posedge I_SMEM_HCLK) begin
    if (state == S_DATA && lat_write) begin
      for (int k = 0; k < 4; k++)
        if (lane_en[k]) mem[lat_waddr][8*k +: 8] <= I_SMEM_HWDATA[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a two-wait instance driven by a pipelined AHB master task.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel2;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] rdata0, rdata2;
  logic        rdy0, rdy2;
  logic [1:0]  resp0, resp2;
  logic [15:0] cnt0, cnt2;

  always #5 clk = ~clk;

  ahb_slave_mem #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u0 (
    .I_SMEM_HCLK(clk), .I_SMEM_HRESET_N(rst_n), .I_SMEM_HSEL(sel0), .I_SMEM_HADDR(haddr),
    .I_SMEM_HTRANS(htrans), .I_SMEM_HWRITE(hwrite), .I_SMEM_HSIZE(hsize), .I_SMEM_HBURST(hburst),
    .I_SMEM_HWDATA(hwdata), .I_SMEM_HREADY(rdy0), .O_SMEM_HRDATA(rdata0), .O_SMEM_HREADY(rdy0),
    .O_SMEM_HRESP(resp0), .O_SMEM_XFER_CNT(cnt0));

  ahb_slave_mem #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u2 (
    .I_SMEM_HCLK(clk), .I_SMEM_HRESET_N(rst_n), .I_SMEM_HSEL(sel2), .I_SMEM_HADDR(haddr),
    .I_SMEM_HTRANS(htrans), .I_SMEM_HWRITE(hwrite), .I_SMEM_HSIZE(hsize), .I_SMEM_HBURST(hburst),
    .I_SMEM_HWDATA(hwdata), .I_SMEM_HREADY(rdy2), .O_SMEM_HRDATA(rdata2), .O_SMEM_HREADY(rdy2),
    .O_SMEM_HRESP(resp2), .O_SMEM_XFER_CNT(cnt2));

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    int          waits;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  beat_t       bq[$];
  exp_t        sb[$];
  logic [31:0] m0 [256];
  logic [31:0] m2 [256];
  int          cm0, cm2;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic s, input logic [1:0] t, input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.sel = s; b.trans = t; b.wr = w; b.size = sz; b.addr = a; b.wdata = d;
    bq.push_back(b);
  endtask

  // Reference behaviour of one beat, applied in issue order to the per-instance array model.
  task automatic push_exp(input int which, input beat_t b);
    exp_t        e;
    logic [31:0] w;
    logic [3:0]  be;
    logic        err;
    int          wa;
    e.waits = 0; e.resp = 2'b00; e.rdata = 32'd0;
    if (b.sel && b.trans[1]) begin
      err = (b.size > 3'd2) || (b.size == 3'd1 && b.addr[0]) ||
            (b.size == 3'd2 && b.addr[1:0] != 2'b00) || (b.addr[31:10] != 22'd0);
      if (err) begin
        e.resp = 2'b01; e.waits = 1;
      end else begin
        e.waits = (which == 2) ? 2 : 0;
        wa = int'(b.addr[9:2]);
        w = (which == 2) ? m2[wa] : m0[wa];
        if (b.wr) begin
          case (b.size)
            3'd0:    be = 4'b0001 << b.addr[1:0];
            3'd1:    be = b.addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
          endcase
          for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = b.wdata[8*k +: 8];
          if (which == 2) m2[wa] = w; else m0[wa] = w;
        end else begin
          e.rdata = w;
        end
        if (which == 2) cm2++; else cm0++;
      end
    end
    sb.push_back(e);
  endtask

  // Pipelined master: address phase of beat i overlaps the data phase of beat i-1.
  task automatic run_bus(input int which);
    int          n;
    int          waits;
    exp_t        e;
    logic        r;
    logic [1:0]  rs;
    logic [31:0] rd;
    n = bq.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        sel0 = (which == 0) && bq[i].sel; sel2 = (which == 2) && bq[i].sel;
        htrans = bq[i].trans; haddr = bq[i].addr; hwrite = bq[i].wr; hsize = bq[i].size;
        push_exp(which, bq[i]);
      end else begin
        sel0 = 1'b0; sel2 = 1'b0; htrans = 2'b00;
      end
      if (i > 0) hwdata = bq[i-1].wdata;
      waits = 0;
      forever begin
        @(negedge clk);
        r  = (which == 2) ? rdy2 : rdy0;
        rs = (which == 2) ? resp2 : resp0;
        rd = (which == 2) ? rdata2 : rdata0;
        if (r || waits > 40) break;
        waits++;
        if (i > 0) chk("resp_wait", 32'(rs), 32'(sb[0].resp));
        @(posedge clk); #1;
      end
      if (i > 0) begin
        e = sb.pop_front();
        chk("waits", 32'(waits), 32'(e.waits));
        chk("resp", 32'(rs), 32'(e.resp));
        chk("rdata", rd, e.rdata);
      end
      @(posedge clk); #1;
    end
    bq.delete();
  endtask

  initial begin
    rst_n = 1'b0; sel0 = 1'b0; sel2 = 1'b0; haddr = 32'd0; hwdata = 32'd0;
    htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hburst = 3'b000;
    cm0 = 0; cm2 = 0;
    #22;
    chk("rst_hready", 32'(rdy0), 32'd1);
    chk("rst_hresp", 32'(resp0), 32'd0);
    chk("rst_hrdata", rdata0, 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_cnt_ws2", 32'(cnt2), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // back-to-back write then read of the same word
    add(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    add(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
    run_bus(0);
    chk("cnt_after_wr_rd", 32'(cnt0), 32'd2);

    // byte and halfword lanes
    add(1, 2'b10, 1, 3'd2, 32'h10, 32'h0);
    add(1, 2'b10, 1, 3'd0, 32'h13, 32'hAA000000);
    add(1, 2'b10, 1, 3'd1, 32'h10, 32'h00005566);
    add(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
    add(1, 2'b10, 1, 3'd2, 32'h14, 32'h0);
    add(1, 2'b10, 1, 3'd1, 32'h16, 32'hBEEF0000);
    add(1, 2'b10, 1, 3'd0, 32'h14, 32'h00000011);
    add(1, 2'b10, 0, 3'd2, 32'h14, 32'h0);
    run_bus(0);
    chk("lanes_model", m0[4], 32'hAA005566);
    chk("cnt_lanes", 32'(cnt0), 32'(cm0 & 16'hFFFF));

    // error beats, mixed with an OKAY read, then array readback
    add(1, 2'b10, 0, 3'd2, 32'h02, 32'h0);
    add(1, 2'b10, 0, 3'd3, 32'h10, 32'h0);
    add(1, 2'b10, 0, 3'd2, 32'h400, 32'h0);
    add(1, 2'b10, 1, 3'd3, 32'h10, 32'hFFFFFFFF);
    add(1, 2'b10, 1, 3'd2, 32'h410, 32'h12121212);
    add(1, 2'b10, 1, 3'd1, 32'h11, 32'h34343434);
    add(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
    run_bus(0);
    chk("cnt_errors", 32'(cnt0), 32'(cm0 & 16'hFFFF));

    // reset in the middle of a write data phase
    add(1, 2'b10, 1, 3'd2, 32'h40, 32'h12345678);
    run_bus(0);
    sel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(posedge clk); #1;
    sel0 = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hready", 32'(rdy0), 32'd1);
    chk("midrst_hresp", 32'(resp0), 32'd0);
    chk("midrst_cnt", 32'(cnt0), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cm0 = 0; cm2 = 0;
    add(1, 2'b10, 0, 3'd2, 32'h40, 32'h0);
    run_bus(0);
    chk("midrst_word", m0[16], 32'h12345678);

    // two wait states, INCR4 with a BUSY, then burst readback
    hburst = 3'b011;
    add(1, 2'b10, 1, 3'd2, 32'h20, 32'h11111111);
    add(1, 2'b11, 1, 3'd2, 32'h24, 32'h22222222);
    add(1, 2'b01, 1, 3'd2, 32'h28, 32'h0);
    add(1, 2'b11, 1, 3'd2, 32'h28, 32'h33333333);
    add(1, 2'b11, 1, 3'd2, 32'h2C, 32'h44444444);
    add(1, 2'b10, 0, 3'd2, 32'h20, 32'h0);
    add(1, 2'b11, 0, 3'd2, 32'h24, 32'h0);
    add(1, 2'b11, 0, 3'd2, 32'h28, 32'h0);
    add(1, 2'b11, 0, 3'd2, 32'h2C, 32'h0);
    run_bus(2);
    chk("cnt_ws2_bursts", 32'(cnt2), 32'd8);
    hburst = 3'b000;
    add(1, 2'b10, 0, 3'd2, 32'h02, 32'h0);
    add(1, 2'b10, 0, 3'd2, 32'h2C, 32'h0);
    run_bus(2);
    chk("cnt_ws2_err", 32'(cnt2), 32'd9);

    // counter wrap
    rst_n = 1'b0; #1 rst_n = 1'b1;
    cm0 = 0;
    sel0 = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h40;
    repeat (65535) @(posedge clk);
    #1 sel0 = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
    chk("cnt_ffff", 32'(cnt0), 32'h0000FFFF);
    cm0 = 65535;
    add(1, 2'b10, 1, 3'd2, 32'h44, 32'h00000001);
    run_bus(0);
    chk("cnt_wrap", 32'(cnt0), 32'd0);
    chk("cnt_wrap_model", 32'(cnt0), 32'(cm0 & 16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
